// File: rtl/scalar_fu_scoreboard.sv
// Scoreboard issue controller for the scalar ALU / LD_ST / BRANCH units.
// Holds one status row per FU plus a register result-status table; gates operand read and writeback.
module scalar_fu_scoreboard #(
  parameter int NUM_FU = 3,
  parameter int REG_W  = 5,
  parameter int NREGS  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      disp_valid_i,
  input  logic [1:0]                disp_fu_i,
  input  logic [REG_W-1:0]          disp_rd_i,
  input  logic [REG_W-1:0]          disp_rs1_i,
  input  logic [REG_W-1:0]          disp_rs2_i,
  input  logic                      disp_wen_i,
  output logic                      disp_ready_o,
  output logic [NUM_FU-1:0]         fu_start_o,
  output logic [NUM_FU*REG_W-1:0]   fu_rd_o,
  output logic [NUM_FU*2*REG_W-1:0] fu_rs_o,
  input  logic [NUM_FU-1:0]         wb_req_i,
  output logic [NUM_FU-1:0]         wb_grant_o,
  output logic [NUM_FU-1:0]         fu_busy_o,
  input  logic                      flush_i
);
  localparam int FU_S_W = 2;
  localparam int FU_LIM = 1 << FU_S_W;

  typedef enum logic [1:0] {
    ROW_IDLE = 2'd0,
    ROW_WAIT = 2'd1,
    ROW_EXEC = 2'd2
  } row_st_e;

  logic [REG_W-1:0]  r_v  [NUM_FU];
  logic [REG_W-1:0]  r1_v [NUM_FU];
  logic [REG_W-1:0]  r2_v [NUM_FU];
  logic [NUM_FU-1:0] rdy1_v, rdy2_v, wait_v, exec_v, idle_v;
  logic [NUM_FU-1:0] war_blk, elig, grant_c;
  logic [FU_LIM-1:0] gnt_ext, idle_ext;
  logic              gnt_found;

  logic              rstat_valid_q [NREGS];
  logic              rstat_valid_d [NREGS];
  logic [FU_S_W-1:0] rstat_fu_q    [NREGS];
  logic [FU_S_W-1:0] rstat_fu_d    [NREGS];

  logic fu_legal, accept, src1_rdy, src2_rdy;

  assign gnt_ext  = FU_LIM'(grant_c);
  assign idle_ext = FU_LIM'(idle_v);
  assign fu_legal = (int'(disp_fu_i) < NUM_FU);

  // A result being retired this cycle still counts as pending for the WAW check.
  assign disp_ready_o = !flush_i && fu_legal && idle_ext[disp_fu_i] &&
                        !(disp_wen_i && (disp_rd_i != '0) && rstat_valid_q[disp_rd_i]);
  assign accept = disp_valid_i && disp_ready_o;

  assign src1_rdy = (disp_rs1_i == '0) || !rstat_valid_q[disp_rs1_i] ||
                    gnt_ext[rstat_fu_q[disp_rs1_i]];
  assign src2_rdy = (disp_rs2_i == '0) || !rstat_valid_q[disp_rs2_i] ||
                    gnt_ext[rstat_fu_q[disp_rs2_i]];

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_row
    row_st_e           st_q, st_d;
    logic [REG_W-1:0]  r_q, r1_q, r2_q;
    logic [FU_S_W-1:0] t1_q, t2_q;
    logic              rdy1_q, rdy2_q;
    logic              sel, start_c, busy_c;

    assign sel = accept && (disp_fu_i == FU_S_W'(gi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) st_q <= ROW_IDLE;
      else         st_q <= st_d;
    end

    always_comb begin
      st_d = st_q;
      if (flush_i) begin
        st_d = ROW_IDLE;
      end else begin
        case (st_q)
          ROW_IDLE: if (sel) st_d = ROW_WAIT;
          ROW_WAIT: if (rdy1_q && rdy2_q) st_d = ROW_EXEC;
          ROW_EXEC: if (grant_c[gi]) st_d = ROW_IDLE;
          default:  st_d = ROW_IDLE;
        endcase
      end
    end

    always_comb begin
      start_c = 1'b0;
      busy_c  = 1'b0;
      case (st_q)
        ROW_WAIT: begin
          busy_c  = 1'b1;
          start_c = !flush_i && rdy1_q && rdy2_q;
        end
        ROW_EXEC: busy_c = 1'b1;
        default:  ;
      endcase
    end

    // Operand flags wake up on the producer's grant; a fresh dispatch reloads the row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_q    <= '0;
        r1_q   <= '0;
        r2_q   <= '0;
        t1_q   <= '0;
        t2_q   <= '0;
        rdy1_q <= 1'b0;
        rdy2_q <= 1'b0;
      end else if (!flush_i) begin
        if (sel) begin
          r_q    <= disp_wen_i ? disp_rd_i : '0;
          r1_q   <= disp_rs1_i;
          r2_q   <= disp_rs2_i;
          t1_q   <= rstat_fu_q[disp_rs1_i];
          t2_q   <= rstat_fu_q[disp_rs2_i];
          rdy1_q <= src1_rdy;
          rdy2_q <= src2_rdy;
        end else begin
          if (!rdy1_q && gnt_ext[t1_q]) rdy1_q <= 1'b1;
          if (!rdy2_q && gnt_ext[t2_q]) rdy2_q <= 1'b1;
        end
      end
    end

    assign fu_start_o[gi]                    = start_c;
    assign fu_busy_o[gi]                     = busy_c;
    assign fu_rd_o[gi*REG_W +: REG_W]        = r_q;
    assign fu_rs_o[gi*2*REG_W +: 2*REG_W]    = {r1_q, r2_q};
    assign r_v[gi]    = r_q;
    assign r1_v[gi]   = r1_q;
    assign r2_v[gi]   = r2_q;
    assign rdy1_v[gi] = rdy1_q;
    assign rdy2_v[gi] = rdy2_q;
    assign wait_v[gi] = (st_q == ROW_WAIT);
    assign exec_v[gi] = (st_q == ROW_EXEC);
    assign idle_v[gi] = (st_q == ROW_IDLE);
  end

  // A writer must wait while any waiting row still has to read the old value of its register.
  always_comb begin
    war_blk = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int j = 0; j < NUM_FU; j++) begin
        if (j != k && wait_v[j] && (r_v[k] != '0) &&
            ((r1_v[j] == r_v[k] && rdy1_v[j]) || (r2_v[j] == r_v[k] && rdy2_v[j])))
          war_blk[k] = 1'b1;
      end
    end
  end

  assign elig = exec_v & wb_req_i & ~war_blk;

  always_comb begin
    grant_c   = '0;
    gnt_found = 1'b0;
    if (!flush_i) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (elig[k] && !gnt_found) begin
          grant_c[k] = 1'b1;
          gnt_found  = 1'b1;
        end
      end
    end
  end

  assign wb_grant_o = grant_c;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rstat_valid_d[i] = rstat_valid_q[i];
      rstat_fu_d[i]    = rstat_fu_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < NREGS; i++) rstat_valid_d[i] = 1'b0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (grant_c[k] && (r_v[k] != '0) && (rstat_fu_q[r_v[k]] == FU_S_W'(k)))
          rstat_valid_d[r_v[k]] = 1'b0;
      end
      if (accept && disp_wen_i && (disp_rd_i != '0)) begin
        rstat_valid_d[disp_rd_i] = 1'b1;
        rstat_fu_d[disp_rd_i]    = disp_fu_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        rstat_valid_q[i] <= 1'b0;
        rstat_fu_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        rstat_valid_q[i] <= rstat_valid_d[i];
        rstat_fu_q[i]    <= rstat_fu_d[i];
      end
    end
  end

endmodule

// File: tb/tb_scalar_fu_scoreboard.sv
// Directed bench for scalar_fu_scoreboard; every fu_start pulse is matched against a queue
// of issues expected from accepted dispatches.
`timescale 1ns/1ps
module tb_scalar_fu_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_valid;
  logic [1:0]  disp_fu;
  logic [4:0]  disp_rd, disp_rs1, disp_rs2;
  logic        disp_wen;
  logic        disp_ready;
  logic [2:0]  fu_start;
  logic [14:0] fu_rd;
  logic [29:0] fu_rs;
  logic [2:0]  wb_req, wb_grant, fu_busy;
  logic        flush;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         fu;
    logic [4:0] rd;
    logic [9:0] rs;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  scalar_fu_scoreboard dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .disp_valid_i (disp_valid),
    .disp_fu_i    (disp_fu),
    .disp_rd_i    (disp_rd),
    .disp_rs1_i   (disp_rs1),
    .disp_rs2_i   (disp_rs2),
    .disp_wen_i   (disp_wen),
    .disp_ready_o (disp_ready),
    .fu_start_o   (fu_start),
    .fu_rd_o      (fu_rd),
    .fu_rs_o      (fu_rs),
    .wb_req_i     (wb_req),
    .wb_grant_o   (wb_grant),
    .fu_busy_o    (fu_busy),
    .flush_i      (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int fu, input int rd, input int rs1, input int rs2, input bit wen);
    exp_t e;
    e.fu = fu;
    e.rd = wen ? 5'(rd) : 5'd0;
    e.rs = {5'(rs1), 5'(rs2)};
    exp_q.push_back(e);
  endtask

  task automatic check_starts();
    for (int k = 0; k < 3; k++) begin
      if (fu_start[k]) begin
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].fu == k) idx = i;
        chk($sformatf("start%0d_expected", k), 32'(idx >= 0), 1);
        if (idx >= 0) begin
          chk($sformatf("start%0d_rd", k), 32'(fu_rd[k*5 +: 5]), 32'(exp_q[idx].rd));
          chk($sformatf("start%0d_rs", k), 32'(fu_rs[k*10 +: 10]), 32'(exp_q[idx].rs));
          exp_q.delete(idx);
        end
      end
    end
  endtask

  task automatic step();
    #1;
    check_starts();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input int fu, input int rd, input int rs1, input int rs2, input bit wen);
    disp_valid = 1'b1;
    disp_fu    = 2'(fu);
    disp_rd    = 5'(rd);
    disp_rs1   = 5'(rs1);
    disp_rs2   = 5'(rs2);
    disp_wen   = wen;
  endtask

  task automatic accept_disp(input int fu, input int rd, input int rs1, input int rs2, input bit wen);
    drive_disp(fu, rd, rs1, rs2, wen);
    #1;
    chk($sformatf("disp_ready_fu%0d_rd%0d", fu, rd), 32'(disp_ready), 1);
    push_exp(fu, rd, rs1, rs2, wen);
    step();
    disp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; disp_valid = 1'b0; disp_fu = 2'd0; disp_rd = 5'd0;
    disp_rs1 = 5'd0; disp_rs2 = 5'd0; disp_wen = 1'b0; wb_req = 3'b000; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_start", 32'(fu_start), 0);
    chk("rst_grant", 32'(wb_grant), 0);
    chk("rst_busy", 32'(fu_busy), 0);
    chk("rst_fu_rd", 32'(fu_rd), 0);
    chk("rst_fu_rs", 32'(fu_rs), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Illegal FU id: never ready, leaves no trace.
    drive_disp(3, 9, 0, 0, 1'b1);
    #1 chk("illegal_ready", 32'(disp_ready), 0);
    step();
    disp_valid = 1'b0; disp_fu = 2'd0;
    #1;
    chk("illegal_busy", 32'(fu_busy), 0);
    chk("illegal_rstat", 32'(disp_ready), 1);

    // Independent op: start in cycle 1 only, grant in cycle 3.
    accept_disp(0, 3, 1, 2, 1'b1);
    chk("A_start_c1", 32'(fu_start), 3'b001);
    chk("A_busy_c1", 32'(fu_busy), 3'b001);
    step();
    chk("A_start_c2", 32'(fu_start), 0);
    step();
    wb_req = 3'b001; disp_fu = 2'd1; disp_rd = 5'd3; disp_wen = 1'b1;
    #1;
    chk("A_grant_c3", 32'(wb_grant), 3'b001);
    chk("A_waw_same_cycle", 32'(disp_ready), 0);
    step();
    wb_req = 3'b000;
    #1;
    chk("A_busy_c4", 32'(fu_busy), 0);
    chk("A_rstat_clear_c4", 32'(disp_ready), 1);

    // RAW: LD_ST waits on x5 until the ALU retires.
    accept_disp(0, 5, 1, 2, 1'b1);
    accept_disp(1, 6, 5, 0, 1'b1);
    chk("B_hold_c2", 32'(fu_start), 0);
    step();
    wb_req = 3'b001;
    #1;
    chk("B_grant", 32'(wb_grant), 3'b001);
    chk("B_hold_G", 32'(fu_start), 0);
    step();
    wb_req = 3'b000;
    #1 chk("B_start_G1", 32'(fu_start), 3'b010);
    step();
    chk("B_start_once", 32'(fu_start), 0);
    wb_req = 3'b010;
    #1 chk("B_ld_grant", 32'(wb_grant), 3'b010);
    step();
    wb_req = 3'b000;

    // Bypass: dispatch in the producer's grant cycle.
    accept_disp(0, 5, 1, 2, 1'b1);
    step();
    wb_req = 3'b001;
    drive_disp(1, 7, 5, 5, 1'b1);
    #1;
    chk("C_bypass_grant", 32'(wb_grant), 3'b001);
    chk("C_bypass_ready", 32'(disp_ready), 1);
    push_exp(1, 7, 5, 5, 1'b1);
    step();
    disp_valid = 1'b0; wb_req = 3'b000;
    #1 chk("C_bypass_start", 32'(fu_start), 3'b010);
    step();
    wb_req = 3'b010;
    #1 chk("C_ld_grant", 32'(wb_grant), 3'b010);
    step();
    wb_req = 3'b000;

    // WAW and structural blocking.
    accept_disp(0, 5, 0, 0, 1'b1);
    disp_fu = 2'd1; disp_rd = 5'd5; disp_wen = 1'b1;
    #1 chk("D_waw_block", 32'(disp_ready), 0);
    disp_wen = 1'b0;
    #1 chk("D_nowrite_ok", 32'(disp_ready), 1);
    disp_fu = 2'd0; disp_rd = 5'd8; disp_wen = 1'b1;
    #1 chk("D_struct_block", 32'(disp_ready), 0);
    step();
    wb_req = 3'b001; disp_fu = 2'd1; disp_rd = 5'd5;
    #1;
    chk("D_grant", 32'(wb_grant), 3'b001);
    chk("D_waw_grant_cycle", 32'(disp_ready), 0);
    step();
    wb_req = 3'b000;
    #1 chk("D_waw_release", 32'(disp_ready), 1);

    // WAR and fixed priority.
    accept_disp(0, 4, 0, 0, 1'b1);
    accept_disp(1, 0, 7, 4, 1'b0);
    chk("E_ld_rd_zero", 32'(fu_rd[9:5]), 0);
    chk("E_ld_rs", 32'(fu_rs[19:10]), {5'd7, 5'd4});
    accept_disp(2, 7, 0, 0, 1'b1);
    chk("E_br_start", 32'(fu_start), 3'b100);
    step();
    wb_req = 3'b100;
    #1 chk("E_war_withheld", 32'(wb_grant), 0);
    step();
    wb_req = 3'b101;
    #1 chk("E_prio_alu", 32'(wb_grant), 3'b001);
    step();
    wb_req = 3'b100;
    #1;
    chk("E_ld_start", 32'(fu_start), 3'b010);
    chk("E_war_still", 32'(wb_grant), 0);
    step();
    #1 chk("E_br_grant", 32'(wb_grant), 3'b100);
    step();
    wb_req = 3'b010;
    #1 chk("E_ld_grant", 32'(wb_grant), 3'b010);
    step();
    wb_req = 3'b000;

    // Flush beats grant, start and dispatch.
    accept_disp(0, 5, 0, 0, 1'b1);
    step();
    accept_disp(1, 6, 5, 0, 1'b1);
    wb_req = 3'b001; flush = 1'b1; disp_fu = 2'd2; disp_rd = 5'd9; disp_wen = 1'b1;
    #1;
    chk("F_grant_masked", 32'(wb_grant), 0);
    chk("F_start_masked", 32'(fu_start), 0);
    chk("F_ready_masked", 32'(disp_ready), 0);
    exp_q.delete();
    step();
    flush = 1'b0; wb_req = 3'b000;
    #1 chk("F_busy_cleared", 32'(fu_busy), 0);
    accept_disp(1, 5, 0, 0, 1'b1);
    step();
    wb_req = 3'b010;
    #1 chk("F_ld_grant", 32'(wb_grant), 3'b010);
    step();
    wb_req = 3'b000;

    // Reset in the middle of an operation.
    accept_disp(0, 3, 1, 2, 1'b1);
    step();
    wb_req = 3'b001;
    #1 rst_n = 1'b0;
    #1;
    chk("G_rst_busy", 32'(fu_busy), 0);
    chk("G_rst_grant", 32'(wb_grant), 0);
    chk("G_rst_start", 32'(fu_start), 0);
    chk("G_rst_fu_rd", 32'(fu_rd), 0);
    chk("G_rst_fu_rs", 32'(fu_rs), 0);
    #2 rst_n = 1'b1;
    wb_req = 3'b000;
    exp_q.delete();
    @(posedge clk); #1;
    disp_fu = 2'd1; disp_rd = 5'd3; disp_wen = 1'b1;
    #1 chk("G_rstat_cleared", 32'(disp_ready), 1);
    disp_fu = 2'd0;
    #1 chk("G_ready_alu", 32'(disp_ready), 1);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
